wb_fb_arbiter: RTL

//  Two-master, one-slave pipelined Wishbone arbiter for the shared framebuffer memory port.

---
 rtl/wb_fb_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/wb_fb_arbiter.sv
// Two-master pipelined Wishbone arbiter for the framebuffer port: m0 (video fetch) has fixed
// priority over m1 (CPU). Optional watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_fb_arbiter #(
    parameter int AWIDTH  = 32,
    parameter int OWIDTH  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              m0_cyc,
    input  logic              m0_stb,
    input  logic              m0_we,
    input  logic [AWIDTH-1:0] m0_adr,
    input  logic [3:0]        m0_sel,
    input  logic [31:0]       m0_dat_m,
    output logic [31:0]       m0_dat_s,
    output logic              m0_ack,
    output logic              m0_stall,
    output logic              m0_err,
    input  logic              m1_cyc,
    input  logic              m1_stb,
    input  logic              m1_we,
    input  logic [AWIDTH-1:0] m1_adr,
    input  logic [3:0]        m1_sel,
    input  logic [31:0]       m1_dat_m,
    output logic [31:0]       m1_dat_s,
    output logic              m1_ack,
    output logic              m1_stall,
    output logic              m1_err,
    output logic              s_cyc,
    output logic              s_stb,
    output logic              s_we,
    output logic [AWIDTH-1:0] s_adr,
    output logic [3:0]        s_sel,
    output logic [31:0]       s_dat_m,
    input  logic [31:0]       s_dat_s,
    input  logic              s_ack,
    input  logic              s_stall,
    output logic [1:0]        gnt
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_G0 = 2'd1, S_G1 = 2'd2} state_t;

    state_t            r_state;
    logic [1:0]        r_gnt;
    logic [OWIDTH-1:0] r_outst;
    logic [OWIDTH-1:0] w_outst_nxt;
    state_t            w_arb;
    logic              w_act;
    logic              w_gcyc;
    logic              w_inc;
    logic              w_dec;
    logic              w_release;
    logic              w_timeout;

    assign gnt   = r_gnt;
    assign w_act = (r_state != S_IDLE);

    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_sel    = '0;
        s_dat_m  = '0;
        m0_ack   = 1'b0;
        m0_stall = 1'b1;
        m0_dat_s = '0;
        m1_ack   = 1'b0;
        m1_stall = 1'b1;
        m1_dat_s = '0;
        w_gcyc   = 1'b0;
        case (r_state)
            S_G0: begin
                s_cyc    = m0_cyc;
                s_stb    = m0_stb;
                s_we     = m0_we;
                s_adr    = m0_adr;
                s_sel    = m0_sel;
                s_dat_m  = m0_dat_m;
                m0_ack   = s_ack;
                m0_stall = s_stall;
                m0_dat_s = s_dat_s;
                w_gcyc   = m0_cyc;
            end
            S_G1: begin
                s_cyc    = m1_cyc;
                s_stb    = m1_stb;
                s_we     = m1_we;
                s_adr    = m1_adr;
                s_sel    = m1_sel;
                s_dat_m  = m1_dat_m;
                m1_ack   = s_ack;
                m1_stall = s_stall;
                m1_dat_s = s_dat_s;
                w_gcyc   = m1_cyc;
            end
            default: ;
        endcase
    end

    // Acks seen while idle are not counted: they belong to an aborted cycle.
    assign w_inc = w_act & s_stb & ~s_stall;
    assign w_dec = w_act & s_ack;

    always_comb begin
        w_outst_nxt = r_outst;
        case ({w_inc, w_dec})
            2'b10:   w_outst_nxt = r_outst + 1'b1;
            2'b01:   w_outst_nxt = r_outst - 1'b1;
            default: w_outst_nxt = r_outst;
        endcase
    end

    assign w_release = w_act & ~w_gcyc & (w_outst_nxt == '0);
    assign w_arb     = m0_cyc ? S_G0 : (m1_cyc ? S_G1 : S_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_gnt   <= 2'b00;
            r_outst <= '0;
        end else if (!w_act || w_release) begin
            // Release re-arbitrates in the same cycle so a waiting master sees no idle gap.
            r_state <= w_arb;
            r_gnt   <= {w_arb == S_G1, w_arb == S_G0};
            r_outst <= '0;
        end else if (w_timeout) begin
            r_state <= S_IDLE;
            r_gnt   <= 2'b00;
            r_outst <= '0;
        end else begin
            r_outst <= w_outst_nxt;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int              WD_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] r_wdog;
    logic            w_progress;

    assign w_progress = w_inc | w_dec;
    assign w_timeout  = w_act & (r_outst != '0) & ~w_progress & (r_wdog == WD_MAX);
    assign m0_err     = w_timeout & (r_state == S_G0);
    assign m1_err     = w_timeout & (r_state == S_G1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_wdog <= '0;
        else if (!w_act || (r_outst == '0) || w_progress || w_timeout)
            r_wdog <= '0;
        else
            r_wdog <= r_wdog + 1'b1;
    end
`else
    assign w_timeout = 1'b0;
    assign m0_err    = 1'b0;
    assign m1_err    = 1'b0;
`endif

endmodule
